// File: rtl/vsynth_sched_pkg.sv
// Shared types and helpers for the voice-synth mux scheduler.
// Select encodings for the MSB-first mux pins and LSB-indexed grants.
package vsynth_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [1:0] PTR_RST = 2'd3;

  // The mux numbers its select pins from the MSB: source 0 drives sel[3].
  function automatic logic [3:0] onehot_msb(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [3:0] onehot_lsb(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational 4-way round-robin picker: first set request strictly after ptr,
// wrapping 3 -> 0, with ptr itself searched last.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] idx;

  always_comb begin
    any = |req;
    win = ptr + 2'd1;
    idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving a shared 4:1 one-hot mux: grants one source for
// a programmable slot, drives sel/ce and tracks what sits in the mux output register.
module mux4_rr_sched
  import vsynth_sched_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [LW-1:0] len,
  output logic [3:0]    sel,
  output logic          ce,
  output logic [3:0]    gnt,
  output logic          last,
  output logic          out_vld,
  output logic [1:0]    out_src
);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [LW-1:0] len_eff;
  logic          any, grant, slot_end, serve_n;
  logic [1:0]    win;
  logic [3:0]    sel_n, gnt_n;
  logic          last_n;

  function automatic logic [1:0] sel_index(input logic [3:0] s);
    if (s[3])      return 2'd0;
    else if (s[2]) return 2'd1;
    else if (s[1]) return 2'd2;
    else           return 2'd3;
  endfunction

  rr_pick_4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  assign len_eff  = (len == '0) ? LW'(1) : len;
  // ptr always holds the current owner while serving, so it doubles as w.
  assign slot_end = (state == SERVE) && ((cnt == LW'(1)) || !req[ptr]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant   = 1'b0;
    case (state)
      IDLE: grant = any;
      SERVE: begin
        if (slot_end) begin
          grant = any;
          if (!any) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Re-arbitration at slot end uses the same path as a grant from idle.
    if (grant) begin
      state_n = SERVE;
      ptr_n   = win;
      cnt_n   = len_eff;
    end
  end

  always_comb begin
    serve_n = (state_n == SERVE);
    sel_n   = serve_n ? onehot_msb(ptr_n) : 4'b0000;
    gnt_n   = serve_n ? onehot_lsb(ptr_n) : 4'b0000;
    last_n  = serve_n && (cnt_n == LW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= PTR_RST;
      cnt     <= '0;
      sel     <= '0;
      ce      <= 1'b0;
      gnt     <= '0;
      last    <= 1'b0;
      out_vld <= 1'b0;
      out_src <= '0;
    end else begin
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      ce      <= serve_n;
      gnt     <= gnt_n;
      last    <= last_n;
      // Mirrors the mux output register, which loads one cycle after ce/sel.
      out_vld <= ce;
      if (ce) out_src <= sel_index(sel);
    end
  end

  sel_onehot_a: assert property (@(posedge clk) $onehot0(sel));
  sel_ce_a:     assert property (@(posedge clk) (sel != 4'b0000) == ce);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: each scenario queues hand-derived
// expected outputs per cycle and compares them after the clock edge.
module tb_mux4_rr_sched;

  localparam int LW = 4;

  typedef struct packed {
    logic [3:0] sel;
    logic       ce;
    logic [3:0] gnt;
    logic       last;
    logic       vld;
    logic [1:0] src;
    logic       src_chk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [LW-1:0] len;
  logic [3:0]    sel;
  logic          ce;
  logic [3:0]    gnt;
  logic          last;
  logic          out_vld;
  logic [1:0]    out_src;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  mux4_rr_sched #(.LW(LW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .sel     (sel),
    .ce      (ce),
    .gnt     (gnt),
    .last    (last),
    .out_vld (out_vld),
    .out_src (out_src)
  );

  always #5 clk = ~clk;

  function automatic exp_t srv(input int w, input bit lst, input bit v, input int s);
    exp_t e;
    logic [3:0] m;
    logic [3:0] g;
    m = 4'b1000;
    g = 4'b0001;
    e.sel     = m >> w;
    e.ce      = 1'b1;
    e.gnt     = g << w;
    e.last    = lst;
    e.vld     = v;
    e.src     = 2'(s);
    e.src_chk = 1'b0;
    return e;
  endfunction

  function automatic exp_t idl(input bit v, input int s);
    exp_t e;
    e.sel     = 4'b0000;
    e.ce      = 1'b0;
    e.gnt     = 4'b0000;
    e.last    = 1'b0;
    e.vld     = v;
    e.src     = 2'(s);
    e.src_chk = 1'b0;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.sel     = sel;
    a.ce      = ce;
    a.gnt     = gnt;
    a.last    = last;
    a.vld     = out_vld;
    a.src     = out_src;
    a.src_chk = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    exp_t e, a;
    for (int n = 0; n < 3; n++) begin
      rst = (n < 2);
      req = 4'b0000;
      len = 4'd0;
      e = idl(1'b0, 0);
      e.src_chk = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e, a;
    for (int n = 0; n < 12; n++) begin
      req = (n < 10) ? 4'b1111 : 4'b0000;
      len = 4'd2;
      if (n < 10) e = srv((n / 2) % 4, (n % 2) == 1, n > 0, ((n - 1) / 2) % 4);
      else        e = idl(n == 10, 0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL round_robin cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
  endtask

  task automatic test_sole_requester();
    exp_t e, a;
    for (int n = 0; n < 9; n++) begin
      req = (n < 7) ? 4'b0100 : 4'b0000;
      len = 4'd3;
      if (n < 7) e = srv(2, ((n + 1) % 3) == 0, n > 0, 2);
      else       e = idl(n == 7, 2);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL sole_requester cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
  endtask

  task automatic test_len_zero_pulse();
    exp_t e, a;
    for (int n = 0; n < 3; n++) begin
      req = (n == 0) ? 4'b1000 : 4'b0000;
      len = 4'd0;
      if (n == 0) e = srv(3, 1'b1, 1'b0, 0);
      else        e = idl(n == 1, 3);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL len_zero_pulse cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0]    req_t [7];
    logic [LW-1:0] len_t [7];
    exp_t          exp_t_tab [7];
    exp_t          e, a;
    req_t = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    // A mid-slot len change must not shorten source 1's slot.
    len_t = '{4'd8, 4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8};
    exp_t_tab[0] = srv(1, 1'b0, 1'b0, 0);
    exp_t_tab[1] = srv(1, 1'b0, 1'b1, 1);
    exp_t_tab[2] = srv(1, 1'b0, 1'b1, 1);
    exp_t_tab[3] = srv(2, 1'b0, 1'b1, 1);
    exp_t_tab[4] = srv(2, 1'b0, 1'b1, 2);
    exp_t_tab[5] = idl(1'b1, 2);
    exp_t_tab[6] = idl(1'b0, 2);
    for (int n = 0; n < 7; n++) begin
      req = req_t[n];
      len = len_t[n];
      exp_q.push_back(exp_t_tab[n]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL early_release cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [3:0]    req_t [6];
    logic [LW-1:0] len_t [6];
    logic          rst_t [6];
    exp_t          exp_t_tab [6];
    exp_t          e, a;
    req_t = '{4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b0000, 4'b0000};
    len_t = '{4'd5, 4'd5, 4'd5, 4'd1, 4'd1, 4'd1};
    rst_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t_tab[0] = srv(2, 1'b0, 1'b0, 0);
    exp_t_tab[1] = srv(2, 1'b0, 1'b1, 2);
    exp_t_tab[2] = idl(1'b0, 0);
    exp_t_tab[2].src_chk = 1'b1;
    exp_t_tab[3] = srv(0, 1'b1, 1'b0, 0);
    exp_t_tab[4] = idl(1'b1, 0);
    exp_t_tab[5] = idl(1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      rst = rst_t[n];
      req = req_t[n];
      len = len_t[n];
      exp_q.push_back(exp_t_tab[n]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if ({a.sel, a.ce, a.gnt, a.last, a.vld} !== {e.sel, e.ce, e.gnt, e.last, e.vld} ||
          ((e.vld || e.src_chk) && a.src !== e.src)) begin
        n_bad++;
        $display("FAIL reset_mid_slot cycle %0d: got sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d; want sel=%b ce=%b gnt=%b last=%b vld=%b src=%0d",
                 n, a.sel, a.ce, a.gnt, a.last, a.vld, a.src, e.sel, e.ce, e.gnt, e.last, e.vld, e.src);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    len = '0;
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_len_zero_pulse();
    test_early_release();
    test_reset_mid_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
